// File: rtl/axi_stream_strip_header.sv
// AXI-Stream header stripper: drops N leading bytes from each packet and
// repacks the rest so every beat but the last is full.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip
);

  localparam int SHW = $clog2(DATA_WD) + 1;
  localparam int KW  = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE, FIRST, BODY, TAIL} state_t;

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  n_q;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;

  logic                    load, in_fire;
  logic                    emit, emit_last;
  logic [DATA_WD-1:0]      emit_data;
  logic [DATA_BYTE_WD-1:0] emit_keep;
  logic [DATA_WD-1:0]      data_m, in_tail_data;
  logic [DATA_BYTE_WD-1:0] in_tail_keep;
  logic [SHW-1:0]          sh_n, sh_wn;
  logic [KW-1:0]           kn, kwn;

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    byte_mask = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
      byte_mask[i*8 +: 8] = {8{k[i]}};
  endfunction

  always_comb begin
    load        = !valid_out || ready_out;
    ready_strip = (state_q == IDLE);
    ready_in    = ((state_q == FIRST) || (state_q == BODY)) && load;
    in_fire     = valid_in && ready_in;

    sh_n  = SHW'({n_q, 3'b000});
    sh_wn = SHW'(DATA_WD) - sh_n;
    kn    = {1'b0, n_q};
    kwn   = KW'(DATA_BYTE_WD) - kn;

    data_m       = data_in & byte_mask(keep_in);
    // Bytes N..k-1 of the incoming beat, left-aligned; empty when k <= N.
    in_tail_data = data_m << sh_n;
    in_tail_keep = keep_in << kn;

    state_d    = state_q;
    res_d      = res_q;
    res_keep_d = res_keep_q;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_data  = '0;
    emit_keep  = '0;

    case (state_q)
      IDLE: begin
        if (valid_strip) state_d = FIRST;
      end
      FIRST: begin
        if (in_fire) begin
          if (!last_in) begin
            res_d      = in_tail_data;
            res_keep_d = in_tail_keep;
            state_d    = BODY;
          end else begin
            state_d = IDLE;
            if (|in_tail_keep) begin
              emit      = 1'b1;
              emit_last = 1'b1;
              emit_data = in_tail_data;
              emit_keep = in_tail_keep;
            end
          end
        end
      end
      BODY: begin
        if (in_fire) begin
          emit       = 1'b1;
          emit_data  = res_q | (data_m >> sh_wn);
          emit_keep  = res_keep_q | (keep_in >> kwn);
          res_d      = in_tail_data;
          res_keep_d = in_tail_keep;
          if (last_in) begin
            if (|in_tail_keep) begin
              state_d = TAIL;
            end else begin
              emit_last = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      TAIL: begin
        if (load) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          emit_data = res_q;
          emit_keep = res_keep_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      res_q      <= '0;
      res_keep_q <= '0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      res_keep_q <= res_keep_d;
      if (valid_strip && ready_strip) n_q <= byte_strip_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (load) begin
      valid_out <= emit;
      if (emit) begin
        data_out <= emit_data;
        keep_out <= emit_keep;
        last_out <= emit_last;
      end
    end
  end

endmodule
